// File: rtl/univ_shift_reg.sv
// Universal shift register with a counted burst mode.
// Modes: hold, load, shift left/right, rotate left/right, clear.
// A burst repeats one shift/rotate step n times under a small IDLE/BUSY/DONE FSM.
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN enables the rotate modes
// (100/101); when it is undefined those codes behave as hold and never start a burst.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [2:0]       mode_q;
  logic [2:0]       op_sel;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             start_burst;

  // True for the codes that may be repeated as a burst.
  function automatic logic burst_mode(input logic [2:0] m);
    logic ok;
    case (m)
      M_SHL, M_SHR: ok = 1'b1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      M_ROTL, M_ROTR: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next register value for one operation; unknown or disabled codes hold.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] nxt;
    case (m)
      M_LOAD:  nxt = ld;
      M_SHL:   nxt = {cur[WIDTH-2:0], sl};
      M_SHR:   nxt = {sr, cur[WIDTH-1:1]};
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      M_ROTL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR:  nxt = {cur[0], cur[WIDTH-1:1]};
`endif
      M_CLEAR: nxt = '0;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // During a burst the latched mode drives the datapath; otherwise the live mode.
  always_comb begin
    op_sel      = (state_q == BUSY) ? mode_q : mode;
    q_d         = apply_op(op_sel, q_q, d, sin_l, sin_r);
    start_burst = (state_q == IDLE) && start && (n != '0) && burst_mode(mode);
  end

  // Register, burst FSM and registered status flags; clr overrides everything.
  always_ff @(posedge clk) begin
    if (!clr) begin
      q_q     <= '0;
      state_q <= IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_burst) begin
            // The accepting edge only captures the request; q is untouched.
            mode_q  <= mode;
            cnt_q   <= n;
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end else begin
            q_q <= q_d;
          end
        end
        BUSY: begin
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // Any start seen here is dropped; q holds for this cycle.
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 4: width of the burst step count.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mode  input  3  operation select (see REQ-012).
REQ-006 SHALL have port d  input  WIDTH  parallel load data.
REQ-007 SHALL have port sin_l  input  1  serial input; enters bit 0 on a left shift.
REQ-008 SHALL have port sin_r  input  1  serial input; enters bit WIDTH-1 on a right shift.
REQ-009 SHALL have ports start (input, 1: burst request) and n (input, CNT_W: burst step count).
REQ-010 SHALL have ports q (output, WIDTH: register contents), sout_l (output, 1: equals q[WIDTH-1]) and sout_r (output, 1: equals q[0]).
REQ-011 SHALL have ports busy (output, 1: burst in progress) and done (output, 1: one-cycle burst-complete pulse).

Function
REQ-012 SHALL decode mode as follows: 000 hold; 001 load q<=d; 010 shl q<={q[WIDTH-2:0],sin_l}; 011 shr q<={sin_r,q[WIDTH-1:1]}; 100 rotl; 101 rotr; 110 clear q<=0; 111 hold.
REQ-013 SHALL, in IDLE with start=0, apply the mode to q at every edge, with 1-cycle latency.
REQ-014 SHALL use FSM states IDLE, BUSY and DONE; busy=1 only in BUSY, and done=1 only in DONE.
REQ-015 SHALL, in IDLE with start=1, n!=0 and mode in {010,011,100,101}, latch mode and n, enter BUSY, and leave q unchanged on that edge.
REQ-016 SHALL, in BUSY, perform one step of the latched mode per edge and decrement the remaining count, sampling sin_l and sin_r live at each step.
REQ-017 SHALL, on the edge that performs the n-th step, move BUSY to DONE; DONE SHALL move to IDLE at the next edge, with q held.
REQ-018 SHALL ignore mode, d, n and start while in BUSY or DONE; a start asserted in DONE SHALL be dropped.
REQ-019 SHALL, on start=1 with n=0 or with a non-shift mode, execute the mode as a single-cycle operation per REQ-013, with no FSM transition.
REQ-020 SHALL drive sout_l and sout_r combinationally from q.

Reset
REQ-021 SHALL, at any edge with clr=0, set q=0, the FSM to IDLE, busy=0, done=0 and the count to 0.
REQ-022 SHALL give clr priority over every mode, start and FSM state, including reset in the middle of a burst.
REQ-023 SHALL resume from IDLE and honour inputs starting at the first edge with clr=1.

Configuration
REQ-024 SHALL, with macro UNIV_SHIFT_REG_ROTATE_EN defined, implement mode 100 as q<={q[WIDTH-2:0],q[WIDTH-1]} and mode 101 as q<={q[0],q[WIDTH-1:1]}, both valid as single-cycle and burst operations.
REQ-025 SHALL, without UNIV_SHIFT_REG_ROTATE_EN, treat modes 100 and 101 as hold; a start with either code SHALL NOT enter BUSY.

Verification (WIDTH=8, CNT_W=4)
REQ-026 SHALL cover: mode=001, d=8'hA5, clr=0 -> q=8'h00 after the edge; clr=1, then one load edge -> q=8'hA5.
REQ-027 SHALL cover: q=8'hA5, mode=010, sin_l=1, one edge -> q=8'h4B, sout_l=0; then mode=011, sin_r=0 from 8'hA5 -> q=8'h52.
REQ-028 SHALL cover: ROTATE_EN defined, q=8'h81, start=1, mode=100, n=3 -> busy=1 for 3 cycles, q=8'h0C, then done=1 for exactly 1 cycle, then IDLE.
REQ-029 SHALL cover: burst with mode=010, n=5, sin_l=1 from q=8'h00, with clr=0 after 2 steps -> q=8'h00, busy=0, done=0 at that edge.
REQ-030 SHALL cover: start=1, n=0, mode=010, sin_l=0 from q=8'h0F -> q=8'h1E after one edge, with busy and done never asserted.
REQ-031 SHALL cover: ROTATE_EN undefined, q=8'h81, start=1, mode=101, n=2 -> q stays 8'h81 and busy stays 0.
